// File: rtl/fpa_controller.sv
// Sequencing FSM for the 8-bit (1/4/3) floating-point adder datapath.
// Drives register enables and reports done, zero and an error code.
module fpa_controller #(
    parameter int MANT_W     = 5,
    parameter int MAX_SHIFTS = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              add_except,
    input  logic              norm_except,
    input  logic [MANT_W-1:0] mant,
    output logic              load_en,
    output logic              add_en,
    output logic              norm_en,
    output logic              norm_load,
    output logic              shift_right,
    output logic              done_en,
    output logic              busy,
    output logic              done,
    output logic              zero,
    output logic [1:0]        err_code
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_ADD, S_ACHK, S_NLOAD,
        S_NCHK, S_NSHR, S_NSHL, S_FIN, S_EXC
    } state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   shift_cnt;
    logic [1:0]         exc_code, next_code;
    logic               shift_needed;

    // Any non-zero mantissa outside 01xxx still needs a shift.
    assign shift_needed = mant[MANT_W-1] || !mant[MANT_W-2];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        next_code  = exc_code;
        case (state)
            S_IDLE:  if (start) next_state = S_LOAD;
            S_LOAD:  next_state = S_ADD;
            S_ADD:   next_state = S_ACHK;
            S_ACHK: begin
                if (add_except) begin
                    next_state = S_EXC;
                    next_code  = 2'b01;
                end else begin
                    next_state = S_NLOAD;
                end
            end
            S_NLOAD: next_state = S_NCHK;
            S_NCHK: begin
                if (norm_except) begin
                    next_state = S_EXC;
                    next_code  = 2'b10;
                end else if (mant == '0) begin
                    next_state = S_FIN;
                end else if (shift_needed && shift_cnt == CNT_W'(MAX_SHIFTS)) begin
                    next_state = S_EXC;
                    next_code  = 2'b11;
                end else if (mant[MANT_W-1]) begin
                    next_state = S_NSHR;
                end else if (mant[MANT_W-2]) begin
                    next_state = S_FIN;
                end else begin
                    next_state = S_NSHL;
                end
            end
            S_NSHR:  next_state = S_NCHK;
            S_NSHL:  next_state = S_NCHK;
            S_FIN:   next_state = S_IDLE;
            S_EXC:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        load_en     = 1'b0;
        add_en      = 1'b0;
        norm_en     = 1'b0;
        norm_load   = 1'b0;
        shift_right = 1'b0;
        done_en     = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_LOAD:  load_en = 1'b1;
            S_ADD:   add_en  = 1'b1;
            S_NLOAD: begin
                norm_en   = 1'b1;
                norm_load = 1'b1;
            end
            S_NSHR: begin
                norm_en     = 1'b1;
                shift_right = 1'b1;
            end
            S_NSHL:  norm_en = 1'b1;
            S_FIN:   done_en = 1'b1;
            default: ;
        endcase
    end

    // Status outputs are registered; zero and err_code persist until the next accepted start.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            shift_cnt <= '0;
            exc_code  <= 2'b00;
            done      <= 1'b0;
            zero      <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            exc_code <= next_code;
            done     <= (state == S_FIN) || (state == S_EXC);
            if (state == S_NLOAD)
                shift_cnt <= '0;
            else if (state == S_NSHR || state == S_NSHL)
                shift_cnt <= shift_cnt + CNT_W'(1);
            if (state == S_IDLE && start) begin
                zero     <= 1'b0;
                err_code <= 2'b00;
            end
            if (state == S_NCHK && !norm_except && mant == '0)
                zero <= 1'b1;
            if (state == S_EXC)
                err_code <= exc_code;
        end
    end

endmodule
